uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Serial transmitter that sits directly downstream of the RV32IM core's 9-bit UART output (valid flag + byte). It turns that output into a real 8N1 serial line. The core issues bytes as single-cycle strobes with no backpressure, so the block absorbs bursts in a FIFO and serializes them at a fixed bit period. Overflow is flagged, never stalled.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range is 2 or more.
- FIFO_AW, default 4: FIFO address width; depth is 2^FIFO_AW (16 by default).

Ports:
- clock  in  1  sole clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- uart_in  in  9  bit 8 is the write strobe; bits 7:0 are the byte. Same encoding as the core's UART output.
- tx  out  1  serial line; idles high.
- fifo_count  out  FIFO_AW+1  number of bytes currently held in the FIFO.
- tx_busy  out  1  high when a frame is in progress or fifo_count is nonzero.
- overflow  out  1  sticky; set when a byte is dropped.

## Operation
- Write:
  - Every cycle with uart_in[8]=1 is one byte.
  - If fifo_count < 2^FIFO_AW at the start of the cycle, the byte is pushed.
  - Otherwise the byte is dropped and overflow is set to 1. overflow clears only on reset.
  - A same-cycle pop does not create room; there is no pass-through.
- Push and pop in the same cycle: fifo_count is unchanged and data is preserved in order.
- Pointers wrap modulo 2^FIFO_AW. fifo_count is a separate counter with range 0..2^FIFO_AW.
- States: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count != 0, pop the head into the shift register, then go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit counter selects the bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. This is unconditional, so there is at least one IDLE cycle between frames.
- Bit-period counter:
  - Counts 0..CLKS_PER_BIT-1 and is zeroed on every state entry.
  - Width is clog2(CLKS_PER_BIT).
- tx is driven from a register, not decoded combinationally from state.
- tx_busy = (state != IDLE) || (fifo_count != 0).

## Timing
- Reset values:
  - tx=1, fifo_count=0, tx_busy=0, overflow=0.
  - State is IDLE; pointers and counters are 0.
  - FIFO contents are don't-care.
- Reset mid-frame: on the cycle after reset is sampled high, tx=1, the FIFO is empty, and overflow=0. A strobe in the reset cycle is discarded.
- Latency for a strobe in cycle 0 into an empty, idle block:
  - fifo_count=1 in cycle 1.
  - The byte is popped in cycle 1 (fifo_count returns to 0 in cycle 2).
  - tx=0 from cycle 2 through cycle 2+CLKS_PER_BIT-1.
- Frame length is 10*CLKS_PER_BIT cycles.
- Back-to-back frames: start bits are 10*CLKS_PER_BIT+1 cycles apart (one IDLE cycle between frames).
- Data bit k occupies cycles 2+(k+1)*CLKS_PER_BIT .. 2+(k+2)*CLKS_PER_BIT-1 relative to the strobe.
- The stop bit ends at cycle 2+10*CLKS_PER_BIT-1.
- tx_busy rises in cycle 1 and falls in the first IDLE cycle with an empty FIFO.

## Test plan
- Single byte, CLKS_PER_BIT=4, strobe 0x41 in cycle 0:
  - tx sequence from cycle 2 is 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles.
  - tx=1 and tx_busy=0 from cycle 42.
  - overflow stays 0.
- Back-to-back, strobes of 0x55, 0xAA, 0x00 in cycles 0–2:
  - fifo_count peaks at 2.
  - Start edges at cycles 2, 43, 84.
  - Decoded bytes are 0x55, 0xAA, 0x00 in order.
- Overflow, default depth, 18 strobes in cycles 0–17 with values 0..17:
  - Byte 17 is dropped; overflow=1 from cycle 18.
  - fifo_count=16 at cycle 18.
  - Bytes 0..16 are transmitted in order; overflow stays 1 afterwards.
- Simultaneous push and pop: with fifo_count=1 and the block IDLE, strobe 0x7E in the pop cycle. fifo_count stays 1 and 0x7E is transmitted next.
- Reset mid-frame: assert reset for one cycle during data bit 3 with 2 bytes queued. The next cycle shows tx=1, fifo_count=0, tx_busy=0, overflow=0, and no further frames.
- Idle check: 500 cycles with no strobes after reset. tx stays 1 and tx_busy stays 0 throughout.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// 8N1 serial transmitter with a strobe-fed FIFO. Bytes arrive as single-cycle
// strobes with no backpressure. A byte that finds the FIFO full is dropped and
// sets a sticky overflow flag.
module uart_tx_buffer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [8:0]         uart_in,
  output logic               tx,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               tx_busy,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   FULL     = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [2:0]         bit_idx, bit_next;
  logic [7:0]         shift_reg, shift_next;
  logic               tx_next;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               push, pop, drop;

  // Fullness is judged on the count at the start of the cycle, so a
  // same-cycle pop never makes room for the incoming byte.
  assign push = uart_in[8] && (fifo_count != FULL);
  assign drop = uart_in[8] && (fifo_count == FULL);

  assign tx_busy = (state != IDLE) || (fifo_count != '0);

  // NOTE: storage is deliberately not reset; emptiness is defined by the
  // pointers and count alone, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= uart_in[7:0];
  end

  // NOTE: every register here uses non-blocking assignment so all of them
  // sample the pre-edge values of their inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
    end
  end

  // NOTE: defaults first so that no path through the case leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    bit_next   = bit_idx;
    shift_next = shift_reg;
    tx_next    = tx;
    pop        = 1'b0;

    // tx_next is the line level for the state being entered, so tx changes
    // on the same edge as the state register.
    case (state)
      IDLE: begin
        cnt_next = '0;
        tx_next  = 1'b1;
        if (fifo_count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
          state_next = DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
            tx_next  = shift_reg[bit_idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          tx_next    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: a queue-based occupancy/timing model predicts
// frames into a scoreboard, and a line monitor decodes tx against it.
module tb_uart_tx_buffer;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int FRAME = 10 * CPB;

  logic          clock = 1'b0;
  logic          reset;
  logic [8:0]    uart_in;
  logic          tx;
  logic [AW:0]   fifo_count;
  logic          tx_busy;
  logic          overflow;

  uart_tx_buffer #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .uart_in    (uart_in),
    .tx         (tx),
    .fifo_count (fifo_count),
    .tx_busy    (tx_busy),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] pend[$];
  logic       ovf;
  int         next_free;
  int         frame_end;
  bit         started = 1'b0;

  // Reference model: a byte is accepted if fewer than DEPTH bytes wait at the
  // start of the cycle; a waiting byte starts a frame once the transmitter has
  // been free, and each frame plus its idle gap takes FRAME+1 cycles.
  always @(negedge clock) begin
    int size0;
    frame_t f;
    if (reset) begin
      pend.delete();
      exp_q.delete();
      ovf       = 1'b0;
      next_free = 0;
      frame_end = -1;
      started   = 1'b1;
    end else if (started) begin
      check("fifo_count", 32'(fifo_count), 32'(pend.size()));
      check("overflow", 32'(overflow), 32'(ovf));
      check("tx_busy", 32'(tx_busy), 32'(pend.size() != 0 || cyc <= frame_end));
      size0 = pend.size();
      if (cyc >= next_free && size0 != 0) begin
        f.data  = pend.pop_front();
        f.start = cyc + 1;
        exp_q.push_back(f);
        next_free = cyc + FRAME + 1;
        frame_end = cyc + FRAME;
      end
      if (uart_in[8]) begin
        if (size0 < DEPTH) pend.push_back(uart_in[7:0]);
        else ovf = 1'b1;
      end
    end
  end

  // Line monitor: detects start bits, checks every cycle of the frame
  // against the expected byte and independently decodes mid-bit samples.
  bit         mon_active = 1'b0;
  bit         mon_has    = 1'b0;
  bit         after_rst  = 1'b0;
  int         mon_start;
  frame_t     mon_exp;
  logic [7:0] dec;

  always @(negedge clock) begin
    int o, k;
    logic lvl;
    if (reset) begin
      mon_active = 1'b0;
      after_rst  = 1'b1;
    end else if (started) begin
      if (after_rst) begin
        check("tx_after_reset", 32'(tx), 32'd1);
        after_rst = 1'b0;
      end
      if (!mon_active && tx !== 1'b1) begin
        mon_active = 1'b1;
        mon_start  = cyc;
        mon_has    = (exp_q.size() != 0);
        if (mon_has) begin
          mon_exp = exp_q[0];
          check("start_cycle", 32'(mon_start), 32'(mon_exp.start));
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame at cycle %0d: got start bit expected idle line", cyc);
        end
      end
      if (mon_active) begin
        o = cyc - mon_start;
        k = o / CPB;
        if (k == 0)      lvl = 1'b0;
        else if (k == 9) lvl = 1'b1;
        else             lvl = mon_exp.data[k-1];
        if (mon_has) check("tx_level", 32'(tx), 32'(lvl));
        if (k >= 1 && k <= 8 && (o % CPB) == CPB / 2) dec[k-1] = tx;
        if (o == FRAME - 1) begin
          if (mon_has) begin
            check("decoded_byte", 32'(dec), 32'(mon_exp.data));
            void'(exp_q.pop_front());
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] b, input logic r);
    @(posedge clock);
    #1;
    uart_in = {v, b};
    reset   = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    uart_in = '0;
    reset   = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);

    // Idle line after reset.
    idle(500);

    // Single byte.
    drive(1'b1, 8'h41, 1'b0);
    idle(45);

    // Back-to-back bytes.
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    idle(130);

    // Overflow: 18 strobes into a 16-deep FIFO.
    for (int i = 0; i < 18; i++) drive(1'b1, 8'(i), 1'b0);
    idle(17 * (FRAME + 1) + 10);

    // Push in the pop cycle.
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b1, 8'h7E, 1'b0);
    idle(90);

    // Reset during data bit 3 of the first of three frames, with a strobe
    // in the reset cycle that must be discarded.
    drive(1'b1, 8'hC3, 1'b0);
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b1, 8'h99, 1'b0);
    idle(16);
    drive(1'b1, 8'hEE, 1'b1);
    idle(100);

    // Random sparse traffic, then a random dense burst.
    repeat (400) drive($urandom_range(0, 19) == 0, 8'($urandom), 1'b0);
    repeat (20) drive(1'b1, 8'($urandom), 1'b0);
    idle(25 * (FRAME + 1));

    check("drained_scoreboard", 32'(exp_q.size()), 32'd0);
    check("monitor_idle", 32'(mon_active), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
